video_timing_gen: RTL

//  Raster timing generator and pixel source feeding the HDMI/DVI encoder (red/green/blue, hsync, vsync, vde).

---
 rtl/video_timing_pkg.sv | 84 ++++++++
 rtl/vtg_pipe.sv | 36 +++
 rtl/video_timing_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : Shared types, colour constants and timing presets for the
//            video timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_FB    = 2'b00,
    PAT_BARS  = 2'b01,
    PAT_GRID  = 2'b10,
    PAT_BLACK = 2'b11
  } pattern_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_e;

  // One slot of the sync/de/pattern delay line; syncs are stored as logical
  // "active" flags so a cleared slot always means "inactive".
  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame;
    logic        use_fb;
    logic [23:0] rgb;
  } vtg_stage_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hsync_pol;
    logic        vsync_pol;
  } vtg_timing_t;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  localparam vtg_timing_t C_TIMING_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hsync_pol: 1'b0, vsync_pol: 1'b0
  };

  localparam vtg_timing_t C_TIMING_1280X720_60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hsync_pol: 1'b1, vsync_pol: 1'b1
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    col = C_BLACK;
    case (idx)
      3'd0:    col = C_WHITE;
      3'd1:    col = C_YELLOW;
      3'd2:    col = C_CYAN;
      3'd3:    col = C_GREEN;
      3'd4:    col = C_MAGENTA;
      3'd5:    col = C_RED;
      3'd6:    col = C_BLUE;
      default: col = C_BLACK;
    endcase
    return col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vtg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vtg_pipe
// Purpose  : Fixed-depth shift register with synchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module vtg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // The clear wipes every slot so no stale active pixel survives a reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing generator with framebuffer fetch and test patterns.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   RD_LATENCY = 2,
  localparam int  HT         = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  VT         = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(HT),
  localparam int  VW         = $clog2(VT)
) (
  input  logic          pix_clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [1:0]    pattern_sel_i,
  output logic          fb_req_o,
  output logic [HW-1:0] fb_x_o,
  output logic [VW-1:0] fb_y_o,
  input  logic [23:0]   fb_rdata_i,
  output logic [7:0]    red_o,
  output logic [7:0]    green_o,
  output logic [7:0]    blue_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          vde_o,
  output logic          frame_start_o,
  output logic          busy_o
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("video_timing_gen: RD_LATENCY must be within 1..4");
    end
  endgenerate

  localparam logic [HW-1:0] C_H_LAST     = HW'(HT - 1);
  localparam logic [VW-1:0] C_V_LAST     = VW'(VT - 1);
  localparam logic [HW-1:0] C_H_ACTIVE   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] C_V_ACTIVE   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] C_HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] C_VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] C_BAR_W      = HW'(H_ACTIVE / 8);
  localparam logic [HW-1:0] C_BAR_COUNT  = HW'(8);

  vtg_state_e    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  pattern_e      pat_q;

  logic          fb_req_q;
  logic [HW-1:0] fb_x_q;
  logic [VW-1:0] fb_y_q;
  vtg_stage_t    s0_q;

  logic [23:0]   rgb_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          vde_q;
  logic          frame_q;

  logic          w_run;
  logic          w_origin;
  logic          w_active;
  pattern_e      w_sel;
  logic [HW-1:0] w_bar_idx;
  vtg_stage_t    w_s0;
  vtg_stage_t    w_late;
  logic [23:0]   w_pix;

  assign w_run     = (state_q == ST_RUN);
  assign w_origin  = (h_q == '0) && (v_q == '0);
  assign w_active  = (h_q < C_H_ACTIVE) && (v_q < C_V_ACTIVE);
  assign w_bar_idx = h_q / C_BAR_W;
  // The first pixel of a frame already uses the freshly latched selection.
  assign w_sel     = w_origin ? pattern_e'(pattern_sel_i) : pat_q;

  // --------------------------------------------------------------------------
  // Run/idle control and raster counters
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (h_q == C_H_LAST) begin
          h_d = '0;
          if (v_q == C_V_LAST) begin
            v_d = '0;
            if (!en_i) begin
              state_d = ST_IDLE;
            end
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  always_ff @(posedge pix_clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= PAT_FB;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      if (w_origin) begin
        pat_q <= w_sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: decode of the current raster position
  // --------------------------------------------------------------------------
  always_comb begin
    w_s0        = '0;
    w_s0.hsync  = (h_q >= C_HS_START) && (h_q < C_HS_END);
    w_s0.vsync  = (v_q >= C_VS_START) && (v_q < C_VS_END);
    w_s0.de     = w_run && w_active;
    w_s0.frame  = w_run && w_origin;
    w_s0.use_fb = 1'b0;
    w_s0.rgb    = C_BLACK;
    case (w_sel)
      PAT_FB: begin
        w_s0.use_fb = 1'b1;
      end
      PAT_BARS: begin
        if (w_bar_idx < C_BAR_COUNT) begin
          w_s0.rgb = bar_colour(w_bar_idx[2:0]);
        end
      end
      PAT_GRID: begin
        if ((h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0)) begin
          w_s0.rgb = C_WHITE;
        end
      end
      PAT_BLACK: begin
        w_s0.rgb = C_BLACK;
      end
      default: begin
        w_s0.rgb = C_BLACK;
      end
    endcase
  end

  always_ff @(posedge pix_clk_i) begin
    if (!rst_n_i) begin
      fb_req_q <= 1'b0;
      fb_x_q   <= '0;
      fb_y_q   <= '0;
      s0_q     <= '0;
    end else begin
      fb_req_q <= w_run && w_active;
      fb_x_q   <= h_q;
      fb_y_q   <= v_q;
      s0_q     <= w_s0;
    end
  end

  // --------------------------------------------------------------------------
  // Delay line matching the framebuffer read latency
  // --------------------------------------------------------------------------
  vtg_pipe #(
    .WIDTH ($bits(vtg_stage_t)),
    .DEPTH (RD_LATENCY)
  ) u_pipe (
    .clk_i  (pix_clk_i),
    .rst_ni (rst_n_i),
    .d_i    (s0_q),
    .q_o    (w_late)
  );

  // --------------------------------------------------------------------------
  // Output register: fb_rdata is valid in the same cycle the delayed slot is
  // --------------------------------------------------------------------------
  always_comb begin
    w_pix = C_BLACK;
    if (w_late.de) begin
      w_pix = w_late.use_fb ? fb_rdata_i : w_late.rgb;
    end
  end

  always_ff @(posedge pix_clk_i) begin
    if (!rst_n_i) begin
      rgb_q   <= C_BLACK;
      vde_q   <= 1'b0;
      frame_q <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      rgb_q   <= w_pix;
      vde_q   <= w_late.de;
      frame_q <= w_late.frame;
      hsync_q <= w_late.hsync ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= w_late.vsync ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign fb_req_o      = fb_req_q;
  assign fb_x_o        = fb_x_q;
  assign fb_y_o        = fb_y_q;
  assign red_o         = rgb_q[23:16];
  assign green_o       = rgb_q[15:8];
  assign blue_o        = rgb_q[7:0];
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign vde_o         = vde_q;
  assign frame_start_o = frame_q;
  assign busy_o        = w_run;

endmodule
`default_nettype wire
